// File: rtl/swan_pkg.sv
// Shared SWAN64/128 constants and the key-schedule FSM state type.
// Imported by the encryption key schedule and its round-step datapath.
package swan_pkg;

   localparam logic [31:0] SWAN_DELTA0    = 32'h9e3779b9;
   localparam int          SWAN_PD        = 24;
   localparam int          SWAN_KEY_SIZE  = 128;
   localparam int          SWAN_SIDE_SIZE = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/enc_key_step_128.sv
// One forward SWAN64/128 key-schedule round: rotate the key right by PD,
// then add delta into its least significant word. That word is the round subkey.
module enc_key_step_128
   import swan_pkg::*;
#(
   parameter int PD = SWAN_PD
)(
   input  logic [SWAN_KEY_SIZE-1:0]  key,
   input  logic [SWAN_SIDE_SIZE-1:0] delta,
   output logic [SWAN_KEY_SIZE-1:0]  next_key,
   output logic [SWAN_SIDE_SIZE-1:0] sk
);

   logic [SWAN_KEY_SIZE-1:0] rot;

   // MSB-first {K[104:127], K[0:103]} is a plain rotate right in [127:0] order.
   assign rot      = {key[PD-1:0], key[SWAN_KEY_SIZE-1:PD]};
   assign next_key = {rot[SWAN_KEY_SIZE-1:SWAN_SIDE_SIZE],
                      rot[SWAN_SIDE_SIZE-1:0] + delta};
   assign sk       = next_key[SWAN_SIDE_SIZE-1:0];

endmodule

// File: rtl/enc_key_schedule_128_iter.sv
// Iterative SWAN64/128 encryption key schedule: streams ROUNDS subkeys, one per
// accepted beat, then holds the final key/delta that seed the decryption schedule.
module enc_key_schedule_128_iter
   import swan_pkg::*;
#(
   parameter int                   KEY_SIZE  = SWAN_KEY_SIZE,
   parameter int                   SIDE_SIZE = SWAN_SIDE_SIZE,
   parameter int                   PD        = SWAN_PD,
   parameter logic [SIDE_SIZE-1:0] DELTA0    = SWAN_DELTA0,
   parameter int                   ROUNDS    = 64
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 start_ready,
   input  logic [KEY_SIZE-1:0]  key_in,
   output logic [SIDE_SIZE-1:0] sk,
   output logic                 sk_valid,
   input  logic                 sk_ready,
   output logic [7:0]           sk_round,
   output logic                 done,
   output logic [KEY_SIZE-1:0]  final_key,
   output logic [SIDE_SIZE-1:0] final_delta,
   output state_t               state_dbg
);

   localparam logic [7:0] LAST_ROUND = 8'(ROUNDS);

   state_t               state;
   logic [KEY_SIZE-1:0]  key_q;
   logic [SIDE_SIZE-1:0] delta_q;

   logic [KEY_SIZE-1:0]  step_key;
   logic [KEY_SIZE-1:0]  step_next;
   logic [SIDE_SIZE-1:0] step_delta;
   logic [SIDE_SIZE-1:0] step_sk;

   // A load steps the incoming master key with DELTA0; a run beat steps the
   // held key with the next delta. Either way step_delta is the new delta.
   always_comb begin
      step_key   = key_q;
      step_delta = delta_q + DELTA0;
      if (state != RUN) begin
         step_key   = key_in;
         step_delta = DELTA0;
      end
   end

   enc_key_step_128 #(
      .PD (PD)
   ) u_step (
      .key      (step_key),
      .delta    (step_delta),
      .next_key (step_next),
      .sk       (step_sk)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high (start with start_ready, sk_valid with sk_ready); a producer
   // holds its payload stable until that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         key_q       <= '0;
         delta_q     <= '0;
         sk          <= '0;
         sk_round    <= '0;
         sk_valid    <= 1'b0;
         start_ready <= 1'b1;
         done        <= 1'b0;
         final_key   <= '0;
         final_delta <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  key_q       <= step_next;
                  delta_q     <= step_delta;
                  sk          <= step_sk;
                  sk_round    <= 8'd1;
                  sk_valid    <= 1'b1;
                  start_ready <= 1'b0;
                  done        <= 1'b0;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (sk_ready) begin
                  if (sk_round == LAST_ROUND) begin
                     sk_valid    <= 1'b0;
                     start_ready <= 1'b1;
                     done        <= 1'b1;
                     final_key   <= key_q;
                     final_delta <= delta_q;
                     state       <= DONE;
                  end else begin
                     key_q    <= step_next;
                     delta_q  <= step_delta;
                     sk       <= step_sk;
                     sk_round <= sk_round + 8'd1;
                  end
               end
            end
            default: begin
               sk_valid    <= 1'b0;
               start_ready <= 1'b1;
               done        <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule
